pe_accumulator: RTL and testbench



---
 rtl/pe_accumulator.sv | 119 +++++++++++
 tb/tb_pe_accumulator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pe_accumulator.sv
// rtl/pe_accumulator.sv - sums ACC_LEN PE products per pixel, scales, saturates, queues in a 2-entry FIFO
// Optional feature macro: ACC_ROUND_EN (round half-up before the output shift).
module pe_accumulator #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_LEN      = 9,
    parameter int ACC_WIDTH    = 20,
    parameter int OUT_SHIFT    = 8,
    localparam int IN_W        = DATA_WIDTH + WEIGHT_WIDTH,
    localparam int CNT_W       = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [IN_W-1:0]       acc_in,
    input  logic                  acc_in_valid,
    input  logic                  acc_clear,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic                  acc_out_valid,
    input  logic                  acc_out_ready,
    output logic [CNT_W-1:0]      acc_count,
    output logic                  acc_overflow
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);
`ifdef ACC_ROUND_EN
    localparam int RND_SH = (OUT_SHIFT == 0) ? 0 : OUT_SHIFT - 1;
    localparam logic [ACC_WIDTH:0] RND =
        (OUT_SHIFT == 0) ? '0 : ((ACC_WIDTH + 1)'(1) << RND_SH);
`endif

    logic [ACC_WIDTH-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [1:0]            fcnt_q, fcnt_d;
    logic                  ov_q, ov_d;

    logic [ACC_WIDTH-1:0]  sum_base;
    logic [ACC_WIDTH-1:0]  total;
    logic [ACC_WIDTH:0]    scaled;
    logic [DATA_WIDTH-1:0] result;
    logic                  last;
    logic                  done;
    logic                  pop;
    logic                  push;
    logic                  drop;

    always_comb begin
        // A window's first product loads the sum, so the stale total left
        // over from the previous window is masked rather than cleared.
        sum_base = (count_q == '0) ? '0 : sum_q;
        total    = sum_base + ACC_WIDTH'(acc_in);
        last     = (count_q == LAST);
        done     = acc_in_valid && !acc_clear && last;

        sum_d   = sum_q;
        count_d = count_q;
        if (acc_clear) begin
            sum_d   = '0;
            count_d = '0;
        end else if (acc_in_valid) begin
            sum_d   = total;
            count_d = last ? '0 : count_q + 1'b1;
        end

`ifdef ACC_ROUND_EN
        scaled = ({1'b0, total} + RND) >> OUT_SHIFT;
`else
        scaled = {1'b0, total} >> OUT_SHIFT;
`endif
        result = (|scaled[ACC_WIDTH:DATA_WIDTH]) ? '1 : scaled[DATA_WIDTH-1:0];
    end

    always_comb begin
        pop  = (fcnt_q != 2'd0) && acc_out_ready;
        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        push = done && ((fcnt_q != 2'd2) || pop);
        drop = done && (fcnt_q == 2'd2) && !pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = result;
        end
        wr_d   = wr_q ^ push;
        rd_d   = rd_q ^ pop;
        fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};
        ov_d   = ov_q | drop;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q    <= '0;
            count_q  <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            fcnt_q   <= 2'd0;
            ov_q     <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            count_q  <= count_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fcnt_q   <= fcnt_d;
            ov_q     <= ov_d;
        end
    end

    assign acc_out       = mem_q[rd_q];
    assign acc_out_valid = (fcnt_q != 2'd0);
    assign acc_count     = count_q;
    assign acc_overflow  = ov_q;

endmodule

// File: tb/tb_pe_accumulator.sv
// tb/tb_pe_accumulator.sv - table-driven self-checking bench for pe_accumulator
module tb_pe_accumulator;

    logic        clk;
    logic        rstn;
    logic [15:0] acc_in;
    logic        acc_in_valid;
    logic        acc_clear;
    logic [7:0]  acc_out;
    logic        acc_out_valid;
    logic        acc_out_ready;
    logic [3:0]  acc_count;
    logic        acc_overflow;

    pe_accumulator dut (
        .clk          (clk),
        .rstn         (rstn),
        .acc_in       (acc_in),
        .acc_in_valid (acc_in_valid),
        .acc_clear    (acc_clear),
        .acc_out      (acc_out),
        .acc_out_valid(acc_out_valid),
        .acc_out_ready(acc_out_ready),
        .acc_count    (acc_count),
        .acc_overflow (acc_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        clear;
        logic        ready;
        logic [3:0]  e_cnt;
        logic        e_valid;
        logic [7:0]  e_out;
        logic        e_ov;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic b_ov  = 1'b0;

`ifdef ACC_ROUND_EN
    localparam logic [7:0] RND_RES = 8'h02;
`else
    localparam logic [7:0] RND_RES = 8'h01;
`endif

    task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic prod(input logic [15:0] d, input logic clr, input logic rdy,
                        input logic [3:0] ec, input logic ev, input logic [7:0] eo);
        vec_t v;
        v.valid = 1'b1; v.data = d; v.clear = clr; v.ready = rdy;
        v.e_cnt = ec; v.e_valid = ev; v.e_out = eo; v.e_ov = b_ov;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic rdy, input logic [3:0] ec, input logic ev, input logic [7:0] eo);
        vec_t v;
        v.valid = 1'b0; v.data = 16'h0; v.clear = 1'b0; v.ready = rdy;
        v.e_cnt = ec; v.e_valid = ev; v.e_out = eo; v.e_ov = b_ov;
        vecs.push_back(v);
    endtask

    // Eight products with a fixed output view, then the completing product.
    task automatic window(input logic [15:0] d, input logic rdy, input logic ev_mid,
                          input logic [7:0] eo_mid, input logic [7:0] eo_end, input logic ov_end);
        for (int i = 0; i < 8; i++) prod(d, 1'b0, rdy, 4'(i + 1), ev_mid, eo_mid);
        b_ov = ov_end;
        prod(d, 1'b0, rdy, 4'd0, 1'b1, eo_end);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic clr, input logic rdy);
        acc_in_valid  = v;
        acc_in        = d;
        acc_clear     = clr;
        acc_out_ready = rdy;
    endtask

    task automatic check_outs(input int idx, input logic [3:0] ec, input logic ev,
                              input logic [7:0] eo, input logic eov);
        chk("acc_count", idx, 16'(acc_count), 16'(ec));
        chk("acc_out_valid", idx, 16'(acc_out_valid), 16'(ev));
        if (ev) chk("acc_out", idx, 16'(acc_out), 16'(eo));
        chk("acc_overflow", idx, 16'(acc_overflow), 16'(eov));
    endtask

    initial begin
        // 1: nine 0x0100 -> 0x09, valid for exactly one cycle
        window(16'h0100, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0);
        idle(1'b1, 4'd0, 1'b0, 8'h00);
        // 2: nine 0xFFFF -> saturated 0xFF
        window(16'hFFFF, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
        idle(1'b1, 4'd0, 1'b0, 8'h00);
        // 3: rounding boundary, total 0x180
        for (int i = 0; i < 8; i++) prod(16'h0000, 1'b0, 1'b1, 4'(i + 1), 1'b0, 8'h00);
        prod(16'h0180, 1'b0, 1'b1, 4'd0, 1'b1, RND_RES);
        idle(1'b1, 4'd0, 1'b0, 8'h00);
        // 4: ready low, three windows; third result dropped
        window(16'h0100, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0);
        window(16'h0200, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0);
        window(16'h0300, 1'b0, 1'b1, 8'h09, 8'h09, 1'b1);
        idle(1'b0, 4'd0, 1'b1, 8'h09);
        idle(1'b1, 4'd0, 1'b1, 8'h12);
        idle(1'b1, 4'd0, 1'b0, 8'h00);
        idle(1'b1, 4'd0, 1'b0, 8'h00);
        // 5: partial window aborted by clear+valid, then a window with a gap
        for (int i = 0; i < 4; i++) prod(16'h0100, 1'b0, 1'b1, 4'(i + 1), 1'b0, 8'h00);
        prod(16'h0100, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) prod(16'h0200, 1'b0, 1'b1, 4'(i + 1), 1'b0, 8'h00);
        idle(1'b1, 4'd4, 1'b0, 8'h00);
        idle(1'b1, 4'd4, 1'b0, 8'h00);
        for (int i = 4; i < 8; i++) prod(16'h0200, 1'b0, 1'b1, 4'(i + 1), 1'b0, 8'h00);
        prod(16'h0200, 1'b0, 1'b1, 4'd0, 1'b1, 8'h12);
        idle(1'b1, 4'd0, 1'b0, 8'h00);

        drive(1'b0, 16'h0, 1'b0, 1'b1);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs(-1, 4'd0, 1'b0, 8'h00, 1'b0);
        chk("acc_out_reset", -1, 16'(acc_out), 16'h0);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].clear, vecs[i].ready);
            @(posedge clk);
            #1;
            check_outs(i, vecs[i].e_cnt, vecs[i].e_valid, vecs[i].e_out, vecs[i].e_ov);
        end

        // 6: async reset mid-window with one result queued
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 16'h0100, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        check_outs(1000, 4'd5, 1'b1, 8'h09, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_outs(1001, 4'd0, 1'b0, 8'h00, 1'b0);
        chk("acc_out_async_reset", 1001, 16'(acc_out), 16'h0);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 16'h0100, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            if (i < 8) check_outs(1002 + i, 4'(i + 1), 1'b0, 8'h00, 1'b0);
            else       check_outs(1002 + i, 4'd0, 1'b1, 8'h09, 1'b0);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_outs(1100, 4'd0, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
